// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IFU/LSU data-memory arbiter: memory op codes,
// FSM states and requester ids.
package mem_arb_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane shaping for one access: store shift/mask, load extract/extend,
// and legality of the op/offset/direction combination.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic        wen,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  output logic [31:0] wdata,
  output logic [3:0]  wmask,
  output logic [31:0] load_data,
  output logic        illegal
);

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic [4:0]  lane_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign is_byte    = (op == MEMOP_B) || (op == MEMOP_BU);
  assign is_half    = (op == MEMOP_H) || (op == MEMOP_HU);
  assign is_word    = (op == MEMOP_W);
  assign lane_shift = {offset, 3'b000};
  assign byte_sel   = read_word[lane_shift +: 8];
  // A legal half access always has offset[0] = 0, so only offset[1] picks the lanes
  assign half_sel   = read_word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    illegal = !(is_byte || is_half || is_word)
              || (wen && op[2])
              || (is_half && offset[0])
              || (is_word && (offset != 2'b00));
  end

  always_comb begin
    wdata = '0;
    wmask = '0;
    if (wen) begin
      wdata = store_data << lane_shift;
      if (is_byte)      wmask = 4'b0001 << offset;
      else if (is_half) wmask = 4'b0011 << offset;
      else              wmask = 4'b1111;
    end
  end

  always_comb begin
    load_data = read_word;
    if (is_byte)
      load_data = op[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    else if (is_half)
      load_data = op[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one data-memory port between
// the IFU (word fetches) and the LSU (byte/half/word loads and stores).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arbitrate, accept winner, latch request, check legality
// ST_ISSUE | MemReqValid high until MemReqReady
// ST_WAIT  | wait for MemRespValid, capture shaped read data
// ST_RESP  | one-cycle response pulse to the granted requester
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        IfuReqValid,
  output logic        IfuReqReady,
  input  logic [31:0] IfuAddr,
  output logic        IfuRespValid,
  output logic [31:0] IfuRdata,
  output logic        IfuErr,
  input  logic        LsuReqValid,
  output logic        LsuReqReady,
  input  logic [31:0] LsuAddr,
  input  logic        LsuWen,
  input  logic [2:0]  LsuMemOp,
  input  logic [31:0] LsuWdata,
  output logic        LsuRespValid,
  output logic [31:0] LsuRdata,
  output logic        LsuErr,
  output logic        MemReqValid,
  input  logic        MemReqReady,
  output logic [31:0] MemAddr,
  output logic        MemWen,
  output logic [31:0] MemWdata,
  output logic [3:0]  MemWmask,
  input  logic        MemRespValid,
  input  logic [31:0] MemRdata
);

  arb_state_e  state;
  arb_state_e  state_nxt;
  logic        last_grant;
  logic        gnt_id;
  logic [31:0] addr_q;
  logic [2:0]  op_q;
  logic        wen_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        ifu_win;
  logic        accept;
  logic [31:0] cand_addr;
  logic [2:0]  cand_op;
  logic        cand_wen;
  logic [31:0] cand_wdata;

  logic [31:0] al_addr;
  logic [2:0]  al_op;
  logic        al_wen;
  logic [31:0] al_wdata;
  logic [31:0] shaped_wdata;
  logic [3:0]  shaped_wmask;
  logic [31:0] load_data;
  logic        illegal;

  logic        in_issue;
  logic        resp_ifu;
  logic        resp_lsu;

  assign ifu_win = IfuReqValid && (!LsuReqValid || (last_grant == GNT_LSU));
  assign accept  = (state == ST_IDLE) && !rst && (IfuReqValid || LsuReqValid);

  always_comb begin
    cand_addr  = LsuAddr;
    cand_op    = LsuMemOp;
    cand_wen   = LsuWen;
    cand_wdata = LsuWdata;
    if (ifu_win) begin
      cand_addr  = IfuAddr;
      cand_op    = MEMOP_W;
      cand_wen   = 1'b0;
      cand_wdata = '0;
    end
  end

  // In IDLE the aligner looks at the arbitration winner so legality is known
  // at acceptance; afterwards it shapes the latched request.
  assign al_addr  = (state == ST_IDLE) ? cand_addr  : addr_q;
  assign al_op    = (state == ST_IDLE) ? cand_op    : op_q;
  assign al_wen   = (state == ST_IDLE) ? cand_wen   : wen_q;
  assign al_wdata = (state == ST_IDLE) ? cand_wdata : wdata_q;

  mem_lane_align u_align (
    .op         (al_op),
    .offset     (al_addr[1:0]),
    .wen        (al_wen),
    .store_data (al_wdata),
    .read_word  (MemRdata),
    .wdata      (shaped_wdata),
    .wmask      (shaped_wmask),
    .load_data  (load_data),
    .illegal    (illegal)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = illegal ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (MemReqReady) state_nxt = ST_WAIT;
      ST_WAIT:  if (MemRespValid) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= GNT_LSU;
      gnt_id     <= GNT_IFU;
      addr_q     <= '0;
      op_q       <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        gnt_id  <= ifu_win ? GNT_IFU : GNT_LSU;
        addr_q  <= cand_addr;
        op_q    <= cand_op;
        wen_q   <= cand_wen;
        wdata_q <= cand_wdata;
        rdata_q <= '0;
        err_q   <= illegal;
      end
      if ((state == ST_WAIT) && MemRespValid)
        rdata_q <= wen_q ? 32'd0 : load_data;
      if (state == ST_RESP)
        last_grant <= gnt_id;
    end
  end

  assign in_issue = (state == ST_ISSUE);
  assign resp_ifu = (state == ST_RESP) && (gnt_id == GNT_IFU);
  assign resp_lsu = (state == ST_RESP) && (gnt_id == GNT_LSU);

  assign IfuReqReady  = accept && ifu_win;
  assign LsuReqReady  = accept && !ifu_win;

  assign MemReqValid  = in_issue;
  assign MemAddr      = in_issue ? {addr_q[31:2], 2'b00} : 32'd0;
  assign MemWen       = in_issue && wen_q;
  assign MemWdata     = in_issue ? shaped_wdata : 32'd0;
  assign MemWmask     = in_issue ? shaped_wmask : 4'd0;

  assign IfuRespValid = resp_ifu;
  assign IfuRdata     = resp_ifu ? rdata_q : 32'd0;
  assign IfuErr       = resp_ifu && err_q;
  assign LsuRespValid = resp_lsu;
  assign LsuRdata     = resp_lsu ? rdata_q : 32'd0;
  assign LsuErr       = resp_lsu && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against an arithmetic byte-lane reference model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        IfuReqValid;
  logic        IfuReqReady;
  logic [31:0] IfuAddr;
  logic        IfuRespValid;
  logic [31:0] IfuRdata;
  logic        IfuErr;
  logic        LsuReqValid;
  logic        LsuReqReady;
  logic [31:0] LsuAddr;
  logic        LsuWen;
  logic [2:0]  LsuMemOp;
  logic [31:0] LsuWdata;
  logic        LsuRespValid;
  logic [31:0] LsuRdata;
  logic        LsuErr;
  logic        MemReqValid;
  logic        MemReqReady;
  logic [31:0] MemAddr;
  logic        MemWen;
  logic [31:0] MemWdata;
  logic [3:0]  MemWmask;
  logic        MemRespValid;
  logic [31:0] MemRdata;

  int vecs = 0;
  int errs = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .IfuReqValid(IfuReqValid), .IfuReqReady(IfuReqReady), .IfuAddr(IfuAddr),
    .IfuRespValid(IfuRespValid), .IfuRdata(IfuRdata), .IfuErr(IfuErr),
    .LsuReqValid(LsuReqValid), .LsuReqReady(LsuReqReady), .LsuAddr(LsuAddr),
    .LsuWen(LsuWen), .LsuMemOp(LsuMemOp), .LsuWdata(LsuWdata),
    .LsuRespValid(LsuRespValid), .LsuRdata(LsuRdata), .LsuErr(LsuErr),
    .MemReqValid(MemReqValid), .MemReqReady(MemReqReady), .MemAddr(MemAddr),
    .MemWen(MemWen), .MemWdata(MemWdata), .MemWmask(MemWmask),
    .MemRespValid(MemRespValid), .MemRdata(MemRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: op -> access size/signedness, legality from size vs offset.
  function automatic void ref_model(
    input bit is_ifu, input logic [31:0] addr, input logic [2:0] op,
    input bit wen, input logic [31:0] wdata, input logic [31:0] rword,
    output bit err, output logic [31:0] maddr, output logic [31:0] mwdata,
    output logic [3:0] mmask, output logic [31:0] rdata);
    int k;
    int size;
    bit sgn;
    bit st;
    logic [31:0] lmask;
    logic [31:0] v;
    k = int'(addr % 4);
    err = 0;
    sgn = 0;
    size = 4;
    st = !is_ifu && wen;
    if (!is_ifu) begin
      case (op)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: err = 1;
      endcase
      if (wen && op >= 3'd4) err = 1;
    end
    if (k % size != 0) err = 1;
    maddr  = addr - 32'(k);
    mwdata = '0;
    mmask  = '0;
    rdata  = '0;
    if (!err && st) begin
      mwdata = wdata << (8 * k);
      mmask  = 4'(((1 << size) - 1) << k);
    end else if (!err) begin
      lmask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      v = (rword >> (8 * k)) & lmask;
      if (sgn && size < 4 && v[8 * size - 1]) v = v | ~lmask;
      rdata = v;
    end
  endfunction

  task automatic run_txn(input bit is_ifu, input logic [31:0] addr, input logic [2:0] op,
                         input bit wen, input logic [31:0] wdata, input logic [31:0] rword,
                         input int rdy_dly, input int rsp_dly);
    bit e_err;
    logic [31:0] e_maddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_mask;
    logic [31:0] e_rdata;
    logic        e_wen;
    ref_model(is_ifu, addr, op, wen, wdata, rword, e_err, e_maddr, e_wdata, e_mask, e_rdata);
    e_wen = !is_ifu && wen;
    if (is_ifu) begin
      IfuReqValid = 1'b1; IfuAddr = addr;
    end else begin
      LsuReqValid = 1'b1; LsuAddr = addr; LsuMemOp = op; LsuWen = wen; LsuWdata = wdata;
    end
    #1;
    vecs++;
    if (IfuReqReady !== is_ifu || LsuReqReady !== !is_ifu) begin
      errs++;
      $display("FAIL accept: ifu_rdy=%b lsu_rdy=%b required ifu=%b", IfuReqReady, LsuReqReady, is_ifu);
    end
    tick();
    IfuReqValid = 1'b0;
    LsuReqValid = 1'b0;
    #1;
    if (!e_err) begin
      for (int i = 0; i <= rdy_dly; i++) begin
        vecs++;
        if (MemReqValid !== 1'b1 || MemAddr !== e_maddr || MemWen !== e_wen ||
            MemWdata !== e_wdata || MemWmask !== e_mask || IfuRespValid || LsuRespValid) begin
          errs++;
          $display("FAIL issue: v=%b addr=%h wen=%b wd=%h m=%b required addr=%h wen=%b wd=%h m=%b",
                   MemReqValid, MemAddr, MemWen, MemWdata, MemWmask, e_maddr, e_wen, e_wdata, e_mask);
        end
        MemReqReady = (i == rdy_dly);
        tick();
        MemReqReady = 1'b0;
        #1;
      end
      for (int i = 0; i <= rsp_dly; i++) begin
        vecs++;
        if (MemReqValid !== 1'b0 || IfuRespValid !== 1'b0 || LsuRespValid !== 1'b0) begin
          errs++;
          $display("FAIL wait: memv=%b ifu_rv=%b lsu_rv=%b required all 0", MemReqValid, IfuRespValid, LsuRespValid);
        end
        MemRespValid = (i == rsp_dly);
        MemRdata = (i == rsp_dly) ? rword : $urandom;
        tick();
        MemRespValid = 1'b0;
        MemRdata = $urandom;
        #1;
      end
    end
    vecs++;
    if (is_ifu) begin
      if (IfuRespValid !== 1'b1 || LsuRespValid !== 1'b0 || IfuErr !== e_err ||
          IfuRdata !== e_rdata || MemReqValid !== 1'b0) begin
        errs++;
        $display("FAIL ifu_resp: rv=%b err=%b rdata=%h memv=%b required rv=1 err=%b rdata=%h memv=0",
                 IfuRespValid, IfuErr, IfuRdata, MemReqValid, e_err, e_rdata);
      end
    end else begin
      if (LsuRespValid !== 1'b1 || IfuRespValid !== 1'b0 || LsuErr !== e_err ||
          LsuRdata !== e_rdata || MemReqValid !== 1'b0) begin
        errs++;
        $display("FAIL lsu_resp: rv=%b err=%b rdata=%h memv=%b required rv=1 err=%b rdata=%h memv=0",
                 LsuRespValid, LsuErr, LsuRdata, MemReqValid, e_err, e_rdata);
      end
    end
    tick();
    vecs++;
    if (IfuRespValid !== 1'b0 || LsuRespValid !== 1'b0) begin
      errs++;
      $display("FAIL resp_pulse: ifu_rv=%b lsu_rv=%b required 0 0", IfuRespValid, LsuRespValid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    IfuReqValid = 0; IfuAddr = 0; LsuReqValid = 0; LsuAddr = 0; LsuWen = 0;
    LsuMemOp = 0; LsuWdata = 0; MemReqReady = 0; MemRespValid = 0; MemRdata = 0;
    repeat (3) @(posedge clk);
    #1;
    IfuReqValid = 1'b1;
    LsuReqValid = 1'b1;
    #1;
    vecs++;
    if (IfuReqReady !== 0 || LsuReqReady !== 0 || IfuRespValid !== 0 || LsuRespValid !== 0 ||
        IfuErr !== 0 || LsuErr !== 0 || MemReqValid !== 0 || MemWen !== 0) begin
      errs++;
      $display("FAIL reset_ctrl: rdy=%b%b rv=%b%b err=%b%b memv=%b wen=%b required all 0",
               IfuReqReady, LsuReqReady, IfuRespValid, LsuRespValid, IfuErr, LsuErr, MemReqValid, MemWen);
    end
    vecs++;
    if (MemAddr !== 0 || MemWdata !== 0 || MemWmask !== 0 || IfuRdata !== 0 || LsuRdata !== 0) begin
      errs++;
      $display("FAIL reset_data: addr=%h wd=%h m=%b ird=%h lrd=%h required all 0",
               MemAddr, MemWdata, MemWmask, IfuRdata, LsuRdata);
    end
    IfuReqValid = 1'b0;
    LsuReqValid = 1'b0;
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ifu_fetch();
    run_txn(1'b1, 32'h8000_0004, 3'd2, 1'b0, 32'd0, 32'hDEAD_BEEF, 0, 0);
    run_txn(1'b1, 32'h0000_1000, 3'd2, 1'b0, 32'd0, 32'h1234_5678, 2, 1);
  endtask

  task automatic test_byte_load();
    run_txn(1'b0, 32'h0000_0103, 3'b000, 1'b0, 32'd0, 32'h80FF_7F01, 0, 0);
    run_txn(1'b0, 32'h0000_0103, 3'b100, 1'b0, 32'd0, 32'h80FF_7F01, 0, 0);
    run_txn(1'b0, 32'h0000_0102, 3'b001, 1'b0, 32'd0, 32'h80FF_7F01, 1, 0);
    run_txn(1'b0, 32'h0000_0102, 3'b101, 1'b0, 32'd0, 32'h80FF_7F01, 0, 1);
  endtask

  task automatic test_half_store();
    run_txn(1'b0, 32'h0000_0102, 3'b001, 1'b1, 32'h1234_ABCD, 32'h5555_5555, 0, 0);
    run_txn(1'b0, 32'h0000_0201, 3'b000, 1'b1, 32'h0000_00A5, 32'h5555_5555, 0, 0);
    run_txn(1'b0, 32'h0000_0300, 3'b010, 1'b1, 32'hCAFE_F00D, 32'h5555_5555, 1, 1);
  endtask

  task automatic test_illegal();
    run_txn(1'b0, 32'h0000_0101, 3'b010, 1'b0, 32'd0, 32'd0, 0, 0);
    run_txn(1'b0, 32'h0000_0100, 3'b100, 1'b1, 32'hFF, 32'd0, 0, 0);
    run_txn(1'b0, 32'h0000_0101, 3'b001, 1'b0, 32'd0, 32'd0, 0, 0);
    run_txn(1'b0, 32'h0000_0100, 3'b011, 1'b0, 32'd0, 32'd0, 0, 0);
    run_txn(1'b1, 32'h0000_0102, 3'b010, 1'b0, 32'd0, 32'd0, 0, 0);
  endtask

  task automatic test_contention();
    bit exp_ifu;
    int b;
    logic [31:0] word;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    IfuAddr = 32'h0000_0040; LsuAddr = 32'h0000_0080;
    LsuMemOp = 3'b010; LsuWen = 1'b0; LsuWdata = 0;
    IfuReqValid = 1'b1;
    LsuReqValid = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      b = 0;
      while (IfuReqReady !== 1'b1 && LsuReqReady !== 1'b1 && b < 8) begin
        tick();
        #1;
        b++;
      end
      exp_ifu = (i % 2 == 0);
      vecs++;
      if (IfuReqReady !== exp_ifu || LsuReqReady !== !exp_ifu) begin
        errs++;
        $display("FAIL rr_grant[%0d]: ifu_rdy=%b lsu_rdy=%b required ifu=%b", i, IfuReqReady, LsuReqReady, exp_ifu);
      end
      word = $urandom;
      tick();
      if (i >= 4) begin
        if (exp_ifu) IfuReqValid = 1'b0; else LsuReqValid = 1'b0;
      end
      #1;
      vecs++;
      if (IfuReqReady !== 1'b0 || LsuReqReady !== 1'b0 || MemReqValid !== 1'b1) begin
        errs++;
        $display("FAIL rr_issue[%0d]: rdy=%b%b memv=%b required 00 1", i, IfuReqReady, LsuReqReady, MemReqValid);
      end
      MemReqReady = 1'b1;
      tick();
      MemReqReady = 1'b0;
      MemRespValid = 1'b1;
      MemRdata = word;
      tick();
      MemRespValid = 1'b0;
      #1;
      vecs++;
      if (IfuRespValid !== exp_ifu || LsuRespValid !== !exp_ifu ||
          (exp_ifu ? IfuRdata : LsuRdata) !== word) begin
        errs++;
        $display("FAIL rr_resp[%0d]: rv=%b%b rdata=%h required ifu=%b rdata=%h",
                 i, IfuRespValid, LsuRespValid, exp_ifu ? IfuRdata : LsuRdata, exp_ifu, word);
      end
      tick();
      #1;
    end
    IfuReqValid = 1'b0;
    LsuReqValid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midflight();
    IfuAddr = 32'h0000_0040;
    IfuReqValid = 1'b1;
    tick();
    IfuReqValid = 1'b0;
    MemReqReady = 1'b1;
    tick();
    MemReqReady = 1'b0;
    rst = 1'b1;
    #1;
    vecs++;
    if (MemReqValid !== 0 || MemAddr !== 0 || IfuRespValid !== 0 || LsuRespValid !== 0 ||
        IfuRdata !== 0 || IfuErr !== 0 || IfuReqReady !== 0 || LsuReqReady !== 0) begin
      errs++;
      $display("FAIL midflight_reset: memv=%b addr=%h rv=%b%b rd=%h err=%b required all 0",
               MemReqValid, MemAddr, IfuRespValid, LsuRespValid, IfuRdata, IfuErr);
    end
    tick();
    rst = 1'b0;
    tick();
    MemRespValid = 1'b1;
    MemRdata = 32'hBAD0_BAD0;
    tick();
    MemRespValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if (IfuRespValid !== 0 || LsuRespValid !== 0 || MemReqValid !== 0) begin
        errs++;
        $display("FAIL late_resp[%0d]: rv=%b%b memv=%b required 0", i, IfuRespValid, LsuRespValid, MemReqValid);
      end
      tick();
    end
    run_txn(1'b1, 32'h0000_0044, 3'd2, 1'b0, 32'd0, 32'h0BAD_F00D, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [2:0]  op;
    bit          ifu;
    for (int i = 0; i < 40; i++) begin
      ifu = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      op = 3'($urandom_range(0, 7));
      run_txn(ifu, a, op, 1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_ifu_fetch();
    test_byte_load();
    test_half_store();
    test_illegal();
    test_contention();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
